rf_access_ctrl: RTL
===================

# rf_access_ctrl

Request/response front-end that owns the register-file port. It accepts read, write and read-modify-write (RMW add) commands over a valid/ready request channel and sequences `rf_wen`/`rf_ren`/`rf_addr`/`rf_wdata` with correct one-cycle registered-read timing. It returns results over a valid/ready response channel. It sits between the datapath/test driver and the RF, and is the only block that drives RF control.

## Interface
- No parameters; data 32 bits, address 2 bits (4 entries), fixed.
- `clk` in 1: single clock, all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept; high only in IDLE.
- `req_op` in 2: 00 read, 01 write, 10 RMW add, 11 illegal.
- `req_addr` in 2: RF entry.
- `req_wdata` in 32: write data, or addend for RMW.
- `rsp_valid` out 1: response present; held until accepted.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_rdata` out 32: read/old value; 0 for write and illegal.
- `rsp_err` out 1: high with response to illegal op.
- `rf_wen` out 1: RF write enable. When 0, the RF registers read data for `rf_addr`.
- `rf_ren` out 1: read-intent qualifier, high only in RD_ISSUE.
- `rf_addr` out 2: RF address.
- `rf_wdata` out 32: RF write data.
- `rf_rdata` in 32: RF registered read data, valid the cycle after address is presented with `rf_wen`=0.
- `ops_done` out 16: count of completed responses, wraps 0xFFFF→0.

## Operation
- States: IDLE, RD_ISSUE, RD_CAP, WR, RSP.
- Request is accepted on a posedge with `req_valid` and `req_ready`. `req_op`, `req_addr` and `req_wdata` are latched into internal registers.
- Transitions out of IDLE on accept:
  - read → RD_ISSUE
  - RMW → RD_ISSUE
  - write → WR
  - illegal → RSP (`rsp_err`=1, `rsp_rdata`=0, no RF access)
- RD_ISSUE: `rf_addr`=latched addr, `rf_wen`=0, `rf_ren`=1. Next state RD_CAP.
- RD_CAP: `rf_wen`=0, `rf_addr` held. `rf_rdata` is captured into the old-value register.
  - read → RSP.
  - RMW → WR.
- WR: `rf_wen`=1, `rf_addr`=latched addr.
  - For write, `rf_wdata` = latched wdata.
  - For RMW, `rf_wdata` = old + latched wdata, mod 2^32; carry is discarded.
  - Next state RSP.
- RSP: `rsp_valid`=1. `rsp_rdata` = old value (read/RMW) or 0 (write/illegal).
  - Leaves to IDLE on `rsp_valid`&&`rsp_ready`.
  - `ops_done` increments on that same edge.
- Outside WR, `rf_wen`=0. Outside RD_ISSUE, `rf_ren`=0. In IDLE, `rf_addr`=0 and `rf_wdata`=0.
- `rf_wen`, `rf_ren`, `rf_addr` and `rf_wdata` are registered outputs; there are no combinational paths from `req_*` to `rf_*`.
- RMW on entries 0–2 still performs the write. The RF returns fixed read values there (0, 5, 4), so the old value reported is the fixed value.
- Only one operation is in flight at a time. Back-to-back requests are separated by at least the IDLE cycle.

## Timing
- Reset (async assert, sync-to-`clk` deassert handled upstream):
  - state=IDLE, `req_ready`=0 during reset, 1 in the first cycle after release.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `rf_wen`=0, `rf_ren`=0, `rf_addr`=0, `rf_wdata`=0.
  - `ops_done`=0.
- Latency is measured from the accept edge E to the first cycle with `rsp_valid`=1:
  - read: 3 cycles (RD_ISSUE, RD_CAP, RSP).
  - write: 2 cycles.
  - RMW: 4 cycles.
  - illegal: 1 cycle.
- Read throughput with `rsp_ready` tied 1: one read per 4 cycles.
- `rsp_valid`, `rsp_rdata` and `rsp_err` stay stable while `rsp_ready`=0. Stall is unlimited.
- `req_ready`=0 in all non-IDLE states. `req_valid` outside IDLE is ignored and not latched.
- Reset mid-operation: all outputs drop asynchronously to reset values and the in-flight op is discarded.
  - If reset asserts during WR before the edge, the RF write does not occur (`rf_wen` forced 0).
  - No response is ever produced for a discarded op.
- `ops_done` wrap: at 0xFFFF, the next response accept yields 0x0000.

## Test plan
- Reset, then write 0xDEADBEEF to addr 3 → `rf_wen`=1 for exactly one cycle with `rf_addr`=3. Response at E+2 with `rsp_rdata`=0, `rsp_err`=0. `ops_done`=1.
- Read addr 3 after that write → `rf_ren`=1 one cycle, `rsp_valid` at E+3, `rsp_rdata`=0xDEADBEEF. Reads of addr 1 and 2 return 5 and 4.
- RMW addr 3 with addend 0x21524111 on stored 0xDEADBEEF → `rsp_rdata`=0xDEADBEEF at E+4. A subsequent read returns 0x00000000 (wrap).
- Illegal op 2'b11 → `rsp_valid` at E+1, `rsp_err`=1, `rsp_rdata`=0, `rf_wen` and `rf_ren` never asserted.
- Hold `rsp_ready`=0 for 10 cycles with `req_valid`=1 throughout → response stable, `req_ready`=0, no second op latched. Release → IDLE, then the next op is accepted.
- Assert `rst_n`=0 during the WR cycle of a write to addr 3 (prior value 0x1) → `rf_wen` falls immediately, no response. A read after release returns 0x1.

Source files
------------

// File: rtl/rf_access_ctrl_if.sv
// Request and response channels between a command source and rf_access_ctrl.
// The master issues commands and consumes responses; the slave is the controller.
interface rf_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rf_access_ctrl.sv
// Single-outstanding read / write / read-modify-write sequencer that owns the
// register-file port and returns one response per accepted command.
module rf_access_ctrl (
  input  logic                   clk,
  input  logic                   rst_n,
  rf_access_ctrl_if.slave        bus,
  output logic                   rf_wen,
  output logic                   rf_ren,
  output logic [1:0]             rf_addr,
  output logic [31:0]            rf_wdata,
  input  logic [31:0]            rf_rdata,
  output logic [15:0]            ops_done
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAP, WR, RSP} state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RMW   = 2'b10;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] wdata_q;
  logic [31:0] old_q;

  // Gated by rst_n so the channel reads not-ready while reset is held.
  assign bus.req_ready = (state == IDLE) && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= OP_READ;
      wdata_q       <= '0;
      old_q         <= '0;
      rf_wen        <= 1'b0;
      rf_ren        <= 1'b0;
      rf_addr       <= '0;
      rf_wdata      <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      ops_done      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            op_q    <= bus.req_op;
            wdata_q <= bus.req_wdata;
            case (bus.req_op)
              OP_READ, OP_RMW: begin
                state   <= RD_ISSUE;
                rf_ren  <= 1'b1;
                rf_addr <= bus.req_addr;
              end
              OP_WRITE: begin
                state    <= WR;
                rf_wen   <= 1'b1;
                rf_addr  <= bus.req_addr;
                rf_wdata <= bus.req_wdata;
              end
              default: begin
                state         <= RSP;
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= 1'b1;
                bus.rsp_rdata <= '0;
              end
            endcase
          end
        end
        RD_ISSUE: begin
          state  <= RD_CAP;
          rf_ren <= 1'b0;
        end
        // The RF registered the address last edge, so rf_rdata is valid now.
        RD_CAP: begin
          old_q <= rf_rdata;
          if (op_q == OP_RMW) begin
            state    <= WR;
            rf_wen   <= 1'b1;
            rf_wdata <= rf_rdata + wdata_q;
          end else begin
            state         <= RSP;
            rf_addr       <= '0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= rf_rdata;
          end
        end
        WR: begin
          state         <= RSP;
          rf_wen        <= 1'b0;
          rf_addr       <= '0;
          rf_wdata      <= '0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= (op_q == OP_RMW) ? old_q : 32'd0;
        end
        RSP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            ops_done      <= ops_done + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
